// File: rtl/add_sub_pipe.sv
// Chunked carry-pipelined adder/subtractor with valid/ready handshaking.
// Each stage sums one CHUNK-wide slice and carries the rest of the operands forward.
module add_sub_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             cout_o,
  output logic             ovf_o,
  output logic             zero_o
);
  localparam int CHUNK = WIDTH / STAGES;

  logic [STAGES-1:0]            vld_q, vld_in, adv;
  logic [STAGES-1:0][WIDTH-1:0] a_q, b_q, sum_q;
  logic [STAGES-1:0][WIDTH-1:0] a_in, b_in, sum_in, sum_d;
  logic [STAGES-1:0]            c_q, c_in, c_d;
  logic                         ovf_q, ovf_d;
  logic [CHUNK:0]               part;

  // Stage inputs: stage 0 sees the ports (B pre-inverted for subtract), later stages the previous register.
  always_comb begin
    vld_in    = '0;
    a_in      = '0;
    b_in      = '0;
    sum_in    = '0;
    c_in      = '0;
    vld_in[0] = in_valid_i;
    a_in[0]   = a_i;
    b_in[0]   = b_i ^ {WIDTH{sub_i}};
    c_in[0]   = sub_i;
    for (int k = 1; k < STAGES; k++) begin
      vld_in[k] = vld_q[k-1];
      a_in[k]   = a_q[k-1];
      b_in[k]   = b_q[k-1];
      sum_in[k] = sum_q[k-1];
      c_in[k]   = c_q[k-1];
    end
  end

  // Advance chain: the only combinational path from out_ready_i to in_ready_o.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !vld_q[STAGES-1] || out_ready_i;
    for (int k = STAGES - 2; k >= 0; k--)
      adv[k] = !vld_q[k] || adv[k+1];
  end

  always_comb begin
    sum_d = sum_in;
    c_d   = '0;
    part  = '0;
    for (int k = 0; k < STAGES; k++) begin
      part = {1'b0, a_in[k][k*CHUNK +: CHUNK]} + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
           + {{CHUNK{1'b0}}, c_in[k]};
      sum_d[k][k*CHUNK +: CHUNK] = part[CHUNK-1:0];
      c_d[k] = part[CHUNK];
    end
    // a^b^s at the MSB recovers the carry into the MSB
    ovf_d = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
          ^ sum_d[STAGES-1][WIDTH-1] ^ c_d[STAGES-1];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      vld_q <= '0;
      a_q   <= '0;
      b_q   <= '0;
      sum_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          vld_q[k] <= vld_in[k];
          if (vld_in[k]) begin
            a_q[k]   <= a_in[k];
            b_q[k]   <= b_in[k];
            sum_q[k] <= sum_d[k];
            c_q[k]   <= c_d[k];
          end
        end
      end
      if (adv[STAGES-1] && vld_in[STAGES-1]) ovf_q <= ovf_d;
    end
  end

  // Last stage's operand copies have no consumer.
  logic unused_ok;
  assign unused_ok = ^{a_q[STAGES-1], b_q[STAGES-1]};

  assign in_ready_o  = adv[0];
  assign out_valid_o = vld_q[STAGES-1];
  assign sum_o       = sum_q[STAGES-1];
  assign cout_o      = c_q[STAGES-1];
  assign ovf_o       = ovf_q;
  assign zero_o      = vld_q[STAGES-1] && (sum_q[STAGES-1] == '0);
endmodule

// File: tb/tb_add_sub_pipe.sv
// Bench for add_sub_pipe: three configurations (32/4, 16/1, 64/8) against a queue-based arithmetic model.
module tb_add_sub_pipe;
  logic        gclk = 1'b0;
  logic        rst_n, in_valid, sub, ordy32;
  logic [63:0] a, b;
  always #5 gclk = ~gclk;

  logic [31:0] s32;
  logic [15:0] s16;
  logic [63:0] s64;
  logic        c32, o32, z32, c16, o16, z16, c64, o64, z64;
  logic [2:0]  ov, ir, ordy;
  logic [66:0] got [3];

  localparam int WS [3] = '{32, 16, 64};
  localparam int SS [3] = '{4, 1, 8};

  add_sub_pipe #(.WIDTH(32), .STAGES(4)) u32 (
    .clk_i(gclk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[0]),
    .a_i(a[31:0]), .b_i(b[31:0]), .sub_i(sub), .out_valid_o(ov[0]), .out_ready_i(ordy32),
    .sum_o(s32), .cout_o(c32), .ovf_o(o32), .zero_o(z32));
  add_sub_pipe #(.WIDTH(16), .STAGES(1)) u16 (
    .clk_i(gclk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[1]),
    .a_i(a[15:0]), .b_i(b[15:0]), .sub_i(sub), .out_valid_o(ov[1]), .out_ready_i(1'b1),
    .sum_o(s16), .cout_o(c16), .ovf_o(o16), .zero_o(z16));
  add_sub_pipe #(.WIDTH(64), .STAGES(8)) u64 (
    .clk_i(gclk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(ir[2]),
    .a_i(a), .b_i(b), .sub_i(sub), .out_valid_o(ov[2]), .out_ready_i(1'b1),
    .sum_o(s64), .cout_o(c64), .ovf_o(o64), .zero_o(z64));

  assign ordy   = {2'b11, ordy32};
  assign got[0] = {z32, o32, c32, 32'd0, s32};
  assign got[1] = {z16, o16, c16, 48'd0, s16};
  assign got[2] = {z64, o64, c64, s64};

  int          n_cmp = 0, n_bad = 0;
  int          pops [3] = '{0, 0, 0};
  logic [66:0] q [3][$];

  // Expected {zero, ovf, cout, sum} from signed/unsigned arithmetic rules.
  function automatic logic [66:0] model(input logic [63:0] av, bv, input logic sv, input int w);
    logic [63:0] mask, ax, bm, bx, s;
    logic [64:0] full;
    logic        c, o, sa, sb, ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    ax   = av & mask;
    bm   = bv & mask;
    bx   = (sv ? ~bv : bv) & mask;
    full = {1'b0, ax} + {1'b0, bx} + {64'd0, sv};
    s    = full[63:0] & mask;
    c    = full[w];
    sa = ax[w-1]; sb = bm[w-1]; ss = s[w-1];
    o  = sv ? (sa != sb && ss != sa) : (sa == sb && ss != sa);
    return {(s == 64'd0), o, c, s};
  endfunction

  task automatic chk(input string nm, input logic [66:0] g, input logic [66:0] e);
    n_cmp++;
    if (g !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, g, e);
    end
  endtask

  always @(negedge gclk) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) q[i].delete();
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (ov[i]) begin
          if (q[i].size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL stray_out%0d: got %h want no result", WS[i], got[i]);
          end else begin
            chk($sformatf("out%0d", WS[i]), got[i], q[i][0]);
            if (ordy[i]) begin
              void'(q[i].pop_front());
              pops[i]++;
            end
          end
        end
        if (in_valid && ir[i]) q[i].push_back(model(a, b, sub, WS[i]));
      end
    end
  end

  // One op into all three pipes; literal checks on the first result and per-config latency.
  task automatic run1(input logic [63:0] av, bv, input logic sv, input logic [66:0] e32, input bit all);
    int lat [3];
    for (int i = 0; i < 3; i++) lat[i] = 0;
    a = av; b = bv; sub = sv; in_valid = 1'b1;
    @(negedge gclk);
    chk("run1_rdy", 67'(ir), 67'(3'b111));
    @(posedge gclk); #1;
    in_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      for (int i = 0; i < 3; i++)
        if (ov[i] && lat[i] == 0) begin
          lat[i] = n;
          if (i == 0) chk("lit32", got[0], e32);
          else if (all) chk($sformatf("lit%0d", WS[i]), got[i], {1'b1, 1'b0, 1'b1, 64'd0});
        end
      @(posedge gclk); #1;
    end
    for (int i = 0; i < 3; i++) chk($sformatf("lat%0d", WS[i]), 67'(lat[i]), 67'(SS[i]));
  endtask

  initial begin
    int p [3];
    int acc, stalls, cnt;
    bit cap;
    logic [66:0] held;
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; sub = 1'b0; ordy32 = 1'b1;
    held = '0;
    repeat (2) @(posedge gclk);
    #1 rst_n = 1'b1;
    chk("reset_out32", got[0], '0);
    chk("reset_out64", got[2], '0);
    chk("reset_ov", 67'(ov), '0);
    chk("reset_rdy", 67'(ir), 67'(3'b111));

    run1(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, {1'b1, 1'b0, 1'b1, 64'd0}, 1'b1);
    run1(64'h8000_0000, 64'd1, 1'b1, {1'b0, 1'b1, 1'b1, 64'h7FFF_FFFF}, 1'b0);
    run1(64'h5, 64'h7, 1'b1, {1'b0, 1'b0, 1'b0, 64'hFFFF_FFFE}, 1'b0);
    run1(64'h7FFF_FFFF, 64'd1, 1'b0, {1'b0, 1'b1, 1'b0, 64'h8000_0000}, 1'b0);
    run1(64'h1234, 64'h1234, 1'b1, {1'b1, 1'b0, 1'b1, 64'd0}, 1'b1);

    // 100 back-to-back random ops
    for (int i = 0; i < 3; i++) p[i] = pops[i];
    stalls = 0;
    for (int i = 0; i < 100; i++) begin
      a = (i % 10 == 0) ? '1 : {$urandom, $urandom};
      b = (i % 10 == 5) ? 64'd0 : {$urandom, $urandom};
      sub = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      @(negedge gclk);
      if (!ir[0]) stalls++;
      @(posedge gclk); #1;
    end
    in_valid = 1'b0;
    repeat (12) @(posedge gclk);
    #1;
    chk("burst_stalls", 67'(stalls), '0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("burst_cnt%0d", WS[i]), 67'(pops[i] - p[i]), 67'(100));
      chk($sformatf("burst_left%0d", WS[i]), 67'(q[i].size()), '0);
    end

    // Consumer stall on the 32/4 pipe
    ordy32 = 1'b0; p[0] = pops[0]; acc = 0; cap = 1'b0;
    for (int i = 0; i < 10; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      sub = 1'($urandom_range(0, 1)); in_valid = 1'b1;
      @(negedge gclk);
      if (ir[0]) acc++;
      if (ov[0] && !cap) begin cap = 1'b1; held = got[0]; end
      @(posedge gclk); #1;
    end
    in_valid = 1'b0;
    chk("stall_accepts", 67'(acc), 67'(SS[0]));
    chk("stall_rdy", 67'(ir[0]), '0);
    chk("stall_ov", 67'(ov[0]), 67'(1));
    chk("stall_hold", got[0], held);
    ordy32 = 1'b1;
    for (int n = 0; n < 30 && q[0].size() != 0; n++) begin
      @(posedge gclk); #1;
    end
    chk("stall_drain", 67'(pops[0] - p[0]), 67'(acc));
    repeat (10) @(posedge gclk);
    #1;

    // Reset with ops in flight
    for (int i = 0; i < 3; i++) begin
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; sub = 1'(i & 1); in_valid = 1'b1;
      @(posedge gclk); #1;
    end
    in_valid = 1'b0; rst_n = 1'b0;
    @(posedge gclk); #1;
    rst_n = 1'b1;
    chk("rst_ov", 67'(ov), '0);
    chk("rst_rdy", 67'(ir), 67'(3'b111));
    chk("rst_out32", got[0], '0);
    cnt = 0;
    repeat (12) begin
      @(negedge gclk);
      if (|ov) cnt++;
    end
    chk("rst_stale", 67'(cnt), '0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    n_bad++;
    $display("FAIL watchdog: got timeout want completion");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/add_sub_pipe.md
ADD_SUB_PIPE -- requirements
Module: add_sub_pipe

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width in bits.
REQ-002 Parameter STAGES, default 4, number of pipeline stages; WIDTH SHALL be an integer multiple of STAGES; CHUNK = WIDTH/STAGES.
REQ-003 clk_i  input  1  sole clock, rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 in_valid_i  input  1  operand set present.
REQ-006 in_ready_o  output  1  block accepts an operand set this cycle.
REQ-007 a_i  input  WIDTH  operand A.
REQ-008 b_i  input  WIDTH  operand B.
REQ-009 sub_i  input  1  0 = A+B, 1 = A-B.
REQ-010 out_valid_o  output  1  result present.
REQ-011 out_ready_i  input  1  consumer takes the result this cycle.
REQ-012 sum_o  output  WIDTH  result, modulo 2^WIDTH.
REQ-013 cout_o  output  1  carry out of MSB; for subtraction 1 = no borrow.
REQ-014 ovf_o  output  1  signed two's-complement overflow.
REQ-015 zero_o  output  1  sum_o equals 0.

Function
REQ-016 Transfer on input SHALL occur when in_valid_i && in_ready_o; transfer on output when out_valid_o && out_ready_i.
REQ-017 Subtraction SHALL be computed as A + ~B + 1 (carry-in 1); addition uses carry-in 0.
REQ-018 Stage k (0..STAGES-1) SHALL compute bits [k*CHUNK +: CHUNK] of the sum using the registered carry from stage k-1 (stage 0 uses the carry-in), registering its partial sum, carry, and the not-yet-summed operand bits.
REQ-019 Each stage SHALL hold a valid bit; stage k advances when stage k+1 is empty or advancing; the last stage advances when out_valid_o is 0 or out_ready_i is 1.
REQ-020 in_ready_o SHALL be 1 when stage 0 is empty or advancing; it SHALL be combinational on out_ready_i only through this advance chain.
REQ-021 Latency SHALL be exactly STAGES cycles from input transfer to out_valid_o rising, with no stall.
REQ-022 Throughput SHALL be one result per cycle while out_ready_i is held 1.
REQ-023 While out_valid_o && !out_ready_i, sum_o, cout_o, ovf_o and zero_o SHALL stay stable, and no in-flight data SHALL be lost or duplicated.
REQ-024 Results SHALL leave in input-acceptance order.
REQ-025 ovf_o SHALL be 1 when the MSB carry-in differs from the MSB carry-out.
REQ-026 zero_o SHALL be derived from the final registered sum, valid only with out_valid_o.
REQ-027 With STAGES = 1, the block SHALL behave as a single registered adder/subtractor with latency 1.
REQ-028 Inputs a_i, b_i, sub_i SHALL be ignored when no input transfer occurs.

Reset
REQ-029 When rst_ni is 0 at a rising edge, all stage valid bits, out_valid_o, sum_o, cout_o, ovf_o and zero_o SHALL be 0.
REQ-030 in_ready_o SHALL be 1 in the first cycle after reset is released.
REQ-031 Reset asserted mid-operation SHALL discard all in-flight operations; no result from before reset SHALL appear afterwards.

Verification
REQ-032 WIDTH=32, STAGES=4, out_ready_i=1: A=0xFFFFFFFF, B=0x00000001, add -> after 4 cycles sum_o=0, cout_o=1, ovf_o=0, zero_o=1.
REQ-033 Subtract A=0x80000000, B=0x00000001 -> sum_o=0x7FFFFFFF, cout_o=1, ovf_o=1, zero_o=0; A=0x00000005, B=0x00000007 -> sum_o=0xFFFFFFFE, cout_o=0, ovf_o=0.
REQ-034 Back-to-back 100 random operations with out_ready_i=1 -> one result per cycle, order and values match a reference model.
REQ-035 out_ready_i held 0 for 10 cycles with in_valid_i=1 -> exactly STAGES operations accepted, in_ready_o then 0, outputs stable; release -> all drain in order, none lost.
REQ-036 Reset asserted for 1 cycle with 3 operations in flight -> out_valid_o=0 afterwards and no stale result emerges.
REQ-037 Repeat REQ-032/REQ-034 with WIDTH=16, STAGES=1 and WIDTH=64, STAGES=8 -> latency equals STAGES, results correct.
